// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: round-robin arbiter sharing one axi_master command port between two write clients.
// Optional WAIT-state timeout is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_write_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                req0_valid,
   input  logic                req1_valid,
   input  logic [ADDR_W-1:0]   req0_addr,
   input  logic [ADDR_W-1:0]   req1_addr,
   input  logic [DATA_W-1:0]   req0_wdata,
   input  logic [DATA_W-1:0]   req1_wdata,
   input  logic [DATA_W/8-1:0] req0_wstrb,
   input  logic [DATA_W/8-1:0] req1_wstrb,
   output logic                req0_done,
   output logic                req1_done,
   output logic                req0_err,
   output logic                req1_err,
   output logic [1:0]          grant,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_ready
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   logic [1:0] state;
   logic       last_grant;
   logic       pick;
   logic       expire;
   // pick=1 selects req1; on a tie the requester not served last wins
   assign pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
`ifdef AXI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
   assign expire = (state == WAIT) && (cnt == CW'(TIMEOUT_CYC - 1));
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         cnt      <= '0;
         req0_err <= 1'b0;
         req1_err <= 1'b0;
      end else begin
         cnt      <= (state == WAIT) ? cnt + 1'b1 : '0;
         req0_err <= expire && !m_ready && grant[0];
         req1_err <= expire && !m_ready && grant[1];
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC != 0);
   assign expire   = 1'b0;
   assign req0_err = 1'b0;
   assign req1_err = 1'b0;
`endif
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= '0;
         m_valid    <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_wstrb    <= '0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
      end else begin
         m_valid   <= 1'b0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         case (state)
            IDLE: if (req0_valid || req1_valid) begin
               grant   <= pick ? 2'b10 : 2'b01;
               m_addr  <= pick ? req1_addr : req0_addr;
               m_wdata <= pick ? req1_wdata : req0_wdata;
               m_wstrb <= pick ? req1_wstrb : req0_wstrb;
               m_valid <= 1'b1;
               state   <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (m_ready || expire) begin
               req0_done <= grant[0];
               req1_done <= grant[1];
               state     <= RESP;
            end
            default: begin
               last_grant <= grant[1];
               grant      <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
